// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: two async read ports, one write port,
// write-protected constant range, and sequenced init after synchronous reset.
module regfile_mp #(
    parameter int WIDTH  = 8,
    parameter int AW     = 4,
    parameter int RO_LO  = 4,
    parameter int RO_HI  = 10,
    parameter int BYPASS = 1,
    parameter logic [WIDTH*(2**AW)-1:0] INIT =
        (WIDTH*(2**AW))'(128'h00000000_00fdfbf9_00ff0100_ff410302)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] di,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] do0,
    output logic [WIDTH-1:0] do1,
    output logic             busy,
    output logic             ro_err
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] RO_LO_A = AW'(RO_LO);
    localparam logic [AW-1:0] RO_HI_A = AW'(RO_HI);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam bit RO_EN = (RO_LO <= RO_HI);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state;
    logic [AW-1:0]    icnt;
    logic [WIDTH-1:0] regs [DEPTH];
    logic             ro_hit;
    logic             wr_ok;

    always_comb begin
        ro_hit = RO_EN && (wa >= RO_LO_A) && (wa <= RO_HI_A);
        wr_ok  = we && rdy && !busy && !ro_hit;
    end

    // The array itself is never reset so it can still map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_INIT;
            icnt   <= '0;
            busy   <= 1'b1;
            ro_err <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    regs[icnt] <= INIT[int'(icnt)*WIDTH +: WIDTH];
                    icnt       <= icnt + 1'b1;
                    ro_err     <= 1'b0;
                    if (icnt == LAST) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    ro_err <= we && rdy && ro_hit;
                    if (wr_ok)
                        regs[wa] <= di;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    always_comb begin
        do0 = '0;
        do1 = '0;
        if (!busy) begin
            do0 = regs[ra0];
            do1 = regs[ra1];
            if (BYPASS != 0 && wr_ok && ra0 == wa) do0 = di;
            if (BYPASS != 0 && wr_ok && ra1 == wa) do1 = di;
        end
    end

endmodule
